// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_pkg
//  Description : Shared types and constants for the pipeline hazard
//                controller: FSM state encoding, forwarding select codes
//                and the forwarding-hit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int REG_W = 5;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_e;

    // EX operand source selects
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // A later-stage writer supplies the operand; x0 is never forwarded
    function automatic logic fwd_hit(input logic [REG_W-1:0] rd,
                                     input logic             we,
                                     input logic [REG_W-1:0] rs);
        return we && (rd != '0) && (rd == rs);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_if
//  Description : Hazard-information and pipeline-control bundle between the
//                datapath and the pipeline controller.
//                master = controller side, slave = datapath side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;

    // Hazard information from the datapath
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rs1;
    logic [4:0] ex_rs2;
    logic [4:0] ex_rd;
    logic       ex_RegWrite;
    logic       ex_MemRead;
    logic       ex_branch_taken;
    logic [4:0] mem_rd;
    logic       mem_RegWrite;
    logic [4:0] wb_rd;
    logic       wb_RegWrite;
    logic       mem_req;
    logic       dmem_ready;

    // Pipeline register controls and forwarding selects
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       mem_wb_flush;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemRead, ex_branch_taken,
        input  mem_rd, mem_RegWrite, wb_rd, wb_RegWrite, mem_req, dmem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en,
        output if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_RegWrite, ex_MemRead, ex_branch_taken,
        output mem_rd, mem_RegWrite, wb_rd, wb_RegWrite, mem_req, dmem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en,
        input  if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b
    );

endinterface
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Combinational EX operand source select for one operand.
//                The younger EX/MEM result wins over MEM/WB.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_sel
    import pipeline_ctrl_pkg::*;
(
    input  wire logic [4:0] ex_rs_i,
    input  wire logic [4:0] mem_rd_i,
    input  wire logic       mem_we_i,
    input  wire logic [4:0] wb_rd_i,
    input  wire logic       wb_we_i,
    output logic      [1:0] fwd_o
);

    // Prioritised source select, nearest producer first
    always_comb begin
        fwd_o = FWD_RF;
        if (fwd_hit(mem_rd_i, mem_we_i, ex_rs_i)) begin
            fwd_o = FWD_EXMEM;
        end else if (fwd_hit(wb_rd_i, wb_we_i, ex_rs_i)) begin
            fwd_o = FWD_MEMWB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Hazard and sequencing controller for the five-stage pipeline.
//                Freezes on data-memory waits, flushes on taken branches,
//                stalls on load-use, selects forwarding, latches a sticky
//                memory-timeout error and keeps saturating perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  wire logic             clk,
    input  wire logic             reset,
    pipeline_ctrl_if.master       pif,
    output logic                  mem_err,
    output logic      [CNT_W-1:0] stall_cnt,
    output logic      [CNT_W-1:0] flush_cnt
);

    // Wait counter is at least 8 bits, wider if the timeout needs it
    localparam int WAIT_W = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic              mem_err_q;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic       w_freeze;
    logic       w_load_use;
    logic       w_branch_flush;
    logic       w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en;
    logic       w_if_id_flush, w_id_ex_flush, w_mem_wb_flush;
    logic [1:0] w_fwd_a, w_fwd_b;

    // The destination-write flag of the EX instruction plays no role here:
    // only a load in EX can create an unforwardable dependency.
    logic w_unused;
    assign w_unused = pif.ex_RegWrite;

    fwd_sel u_fwd_a (
        .ex_rs_i  (pif.ex_rs1),
        .mem_rd_i (pif.mem_rd),
        .mem_we_i (pif.mem_RegWrite),
        .wb_rd_i  (pif.wb_rd),
        .wb_we_i  (pif.wb_RegWrite),
        .fwd_o    (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .ex_rs_i  (pif.ex_rs2),
        .mem_rd_i (pif.mem_rd),
        .mem_we_i (pif.mem_RegWrite),
        .wb_rd_i  (pif.wb_rd),
        .wb_we_i  (pif.wb_RegWrite),
        .fwd_o    (w_fwd_b)
    );

    // Hazard conditions from current state and inputs
    always_comb begin
        w_freeze = ((state_q == ST_RUN)  && pif.mem_req && !pif.dmem_ready) ||
                   ((state_q == ST_WAIT) && !pif.dmem_ready) ||
                   (state_q == ST_ERR);
        w_load_use = pif.ex_MemRead && (pif.ex_rd != '0) &&
                     ((pif.id_uses_rs1 && (pif.ex_rd == pif.id_rs1)) ||
                      (pif.id_uses_rs2 && (pif.ex_rd == pif.id_rs2)));
        w_branch_flush = reset && !w_freeze && pif.ex_branch_taken;
    end

    // Pipeline controls: reset > freeze > branch flush > load-use > normal
    always_comb begin
        w_pc_en        = 1'b1;
        w_if_id_en     = 1'b1;
        w_id_ex_en     = 1'b1;
        w_ex_mem_en    = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_flush  = 1'b0;
        w_mem_wb_flush = 1'b0;
        if (!reset) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_mem_wb_flush = 1'b1;
        end else if (w_freeze) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_en     = 1'b0;
            w_ex_mem_en    = 1'b0;
            w_mem_wb_flush = 1'b1;
        end else if (pif.ex_branch_taken) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
        end else if (w_load_use) begin
            w_pc_en        = 1'b0;
            w_if_id_en     = 1'b0;
            w_id_ex_flush  = 1'b1;
        end
    end

    assign pif.pc_en        = w_pc_en;
    assign pif.if_id_en     = w_if_id_en;
    assign pif.id_ex_en     = w_id_ex_en;
    assign pif.ex_mem_en    = w_ex_mem_en;
    assign pif.if_id_flush  = w_if_id_flush;
    assign pif.id_ex_flush  = w_id_ex_flush;
    assign pif.mem_wb_flush = w_mem_wb_flush;
    assign pif.fwd_a        = reset ? w_fwd_a : FWD_RF;
    assign pif.fwd_b        = reset ? w_fwd_b : FWD_RF;

    // Memory-wait sequencer with timeout and sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (pif.mem_req && !pif.dmem_ready) begin
                        state_q    <= ST_WAIT;
                        wait_cnt_q <= WAIT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (pif.dmem_ready) begin
                        state_q    <= ST_RUN;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == C_TIMEOUT) begin
                        state_q    <= ST_ERR;
                        mem_err_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating next values of the perf counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (reset && !w_pc_en && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (w_branch_flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Perf counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage RISC-V pipeline. It drives the enable and flush (bubble) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and it selects the EX-stage operand forwarding sources. It freezes the pipeline while the data memory is not ready, and it latches a sticky error on a memory timeout. It also keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `MEM_TIMEOUT`, default 255: maximum wait cycles for a data-memory access before the block enters the error state.
- `CNT_W`, default 32: width of the performance counters.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction actually reads that source.
- `ex_rs1`, `ex_rs2` in 5 each: source registers of the instruction in EX.
- `ex_rd` in 5; `ex_RegWrite`, `ex_MemRead` in 1 each: destination and control bits of the instruction in EX.
- `ex_branch_taken` in 1: branch or jump in EX resolved as taken.
- `mem_rd` in 5; `mem_RegWrite` in 1: destination and write enable of the instruction in MEM.
- `wb_rd` in 5; `wb_RegWrite` in 1: destination and write enable of the instruction in WB.
- `mem_req` in 1: the MEM instruction is accessing data memory (load or store).
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1 each: register update enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: load a bubble (all control bits 0).
- `fwd_a`, `fwd_b` out 2 each: EX operand source. 00 = register file, 10 = EX/MEM result, 01 = MEM/WB result.
- `mem_err` out 1: sticky memory-timeout error.
- `stall_cnt`, `flush_cnt` out `CNT_W` each: performance counters.

## Operation
- FSM states:
  - RUN.
  - WAIT, which holds an 8-bit-or-wider `wait_cnt`.
  - ERR.
- Transitions:
  - RUN→WAIT when `mem_req` is 1 and `dmem_ready` is 0; `wait_cnt` is set to 1 on entry.
  - WAIT→RUN on the cycle `dmem_ready`=1.
  - WAIT→ERR when `wait_cnt`==`MEM_TIMEOUT` and `dmem_ready`=0.
  - ERR is left only by reset.
- Freeze condition: (RUN and `mem_req` and not `dmem_ready`), or WAIT with `dmem_ready`=0, or ERR. During a freeze:
  - `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are 0.
  - `mem_wb_flush` is 1.
  - All other flushes are 0.
- Branch flush (no freeze, `ex_branch_taken`=1):
  - All enables are 1.
  - `if_id_flush` and `id_ex_flush` are 1.
- Load-use stall (no freeze, no branch): the stall fires when `ex_MemRead`=1, `ex_rd`≠0, and either (`id_uses_rs1` and `ex_rd`==`id_rs1`) or (`id_uses_rs2` and `ex_rd`==`id_rs2`). Then:
  - `pc_en` and `if_id_en` are 0.
  - `id_ex_flush` is 1.
  - `id_ex_en` and `ex_mem_en` are 1.
- Normal: all enables are 1 and all flushes are 0.
- Priority, highest first: reset > freeze > branch flush > load-use stall > normal.
- A taken branch held during a freeze is acted on in the first unfrozen cycle, because EX is held.
- Forwarding for `fwd_a` (same rules for `fwd_b` with `ex_rs2`):
  - 10 if `mem_RegWrite`, `mem_rd`≠0 and `mem_rd`==`ex_rs1`.
  - Otherwise 01 if `wb_RegWrite`, `wb_rd`≠0 and `wb_rd`==`ex_rs1`.
  - Otherwise 00.
  - x0 is never forwarded.
- Counters:
  - `stall_cnt` increments on every cycle with `pc_en`=0 while out of reset.
  - `flush_cnt` increments on every branch-flush cycle.
  - Both saturate at all-ones.

## Timing
- All enables, flushes and forwarding selects are combinational from the inputs and the current state, valid in the same cycle.
- The FSM, `wait_cnt`, counters and `mem_err` are registered and update on the rising edge of `clk`.
- While `reset`=0:
  - Enables are 0, flushes are 1, and `fwd_a`/`fwd_b` are 00.
  - At the edge, the state goes to RUN and `wait_cnt`, `stall_cnt`, `flush_cnt` and `mem_err` go to 0.
- Load-use stall costs exactly one cycle. On the next cycle the load is in MEM and `fwd` selects 10 as needed.
- Memory wait: the freeze starts in the same cycle `mem_req`=1 and `dmem_ready`=0. The first cycle with `dmem_ready`=1 is unfrozen.
- Timeout: with `dmem_ready` held at 0, the block freezes on the request cycle plus `MEM_TIMEOUT` WAIT cycles, then enters ERR. `mem_err` rises one cycle after the last WAIT cycle and stays 1 until reset.
- A reset asserted mid-WAIT or in ERR aborts immediately at the next edge.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - The FSM state enum (RUN, WAIT, ERR).
  - The forwarding select constants `FWD_RF`=00, `FWD_EXMEM`=10, `FWD_MEMWB`=01.
- Sub-module `fwd_sel`: purely combinational, instantiated twice (operand A and operand B).
- The top level holds the FSM, hazard detection and counters.

## Test plan
- Load-use: `x5`=lw in EX (`ex_MemRead`=1, `ex_rd`=5), `id_rs1`=5 with `id_uses_rs1`=1 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; next cycle normal with `fwd_a`=10; `stall_cnt`=1.
- Branch and load-use together: both conditions true → `if_id_flush`=`id_ex_flush`=1, `pc_en`=1, `flush_cnt`+1, `stall_cnt` unchanged.
- Forwarding priority: `mem_rd`=`wb_rd`=`ex_rs2`=7, both write enables 1 → `fwd_b`=10. With `mem_rd`=0 → 01. With `ex_rs2`=0 → 00.
- Memory wait: `mem_req`=1 with `dmem_ready` low for 3 cycles then high → freeze for 3 cycles with `mem_wb_flush`=1, unfrozen on the 4th; `stall_cnt`=3.
- Timeout: `MEM_TIMEOUT`=4, `dmem_ready` held at 0 → ERR entered, `mem_err`=1 and freeze persists for 20 more cycles; reset low for one cycle → RUN, all counters 0, `mem_err`=0.
- Reset during WAIT: `reset`=0 for one cycle → outputs are in the reset pattern that cycle, state is RUN after the edge.
